fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx.sv | 155 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an upstream byte FIFO and serialises each one
// as an 8N1 UART frame (start 0, eight data bits LSB first, stop 1).
// A FETCH cycle issues the pop and a LOAD cycle captures the returned byte,
// so back-to-back frames are separated by exactly two idle-high cycles.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              byte_done
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       BIT_LAST = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_clk_cnt;
    logic [CNT_W-1:0]  w_clk_cnt_next;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_idx_next;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_next;
    logic              r_tx;
    logic              w_tx_next;
    logic              r_byte_done;
    logic              w_byte_done_next;
    logic              w_bit_end;
    logic              w_can_start;

    // Last cycle of the current bit period, and permission to begin a new frame.
    assign w_bit_end   = (r_clk_cnt == CNT_LAST);
    assign w_can_start = tx_en & ~fifo_empty;

    // Next-state, counter, shift-register and next-tx decode.
    // tx is computed for the state being entered so the line flop changes on
    // the same edge as the state register.
    always_comb begin
        w_state_next     = r_state;
        w_clk_cnt_next   = r_clk_cnt;
        w_bit_idx_next   = r_bit_idx;
        w_shift_next     = r_shift;
        w_tx_next        = 1'b1;
        w_byte_done_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clk_cnt_next = '0;
                if (w_can_start) begin
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_FETCH: begin
                w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_shift_next   = fifo_data;
                w_clk_cnt_next = '0;
                w_state_next   = S_START;
                w_tx_next      = 1'b0;
            end
            S_START: begin
                w_tx_next = 1'b0;
                if (w_bit_end) begin
                    w_state_next   = S_DATA;
                    w_clk_cnt_next = '0;
                    w_bit_idx_next = 3'd0;
                    w_tx_next      = r_shift[0];
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CNT_ONE;
                end
            end
            S_DATA: begin
                w_tx_next = r_shift[0];
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    w_shift_next   = {1'b0, r_shift[DATA_W-1:1]};
                    if (r_bit_idx == BIT_LAST) begin
                        w_state_next = S_STOP;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                        w_tx_next      = r_shift[1];
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CNT_ONE;
                end
            end
            S_STOP: begin
                w_tx_next = 1'b1;
                if (w_bit_end) begin
                    w_clk_cnt_next   = '0;
                    w_byte_done_next = 1'b1;
                    if (w_can_start) begin
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_next   = S_IDLE;
                w_clk_cnt_next = '0;
                w_bit_idx_next = 3'd0;
            end
        endcase
    end

    // State, counters, shift register and registered line/pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= '0;
            r_tx        <= 1'b1;
            r_byte_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_clk_cnt   <= w_clk_cnt_next;
            r_bit_idx   <= w_bit_idx_next;
            r_shift     <= w_shift_next;
            r_tx        <= w_tx_next;
            r_byte_done <= w_byte_done_next;
        end
    end

    // The pop request and busy flag are pure decodes of the state register.
    assign fifo_rd_en = (r_state == S_FETCH);
    assign busy       = (r_state != S_IDLE);
    assign tx         = r_tx;
    assign byte_done  = r_byte_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-based FIFO model feeds the DUT, and a
// frame-level monitor decodes tx against 8N1 timing rules and compares each
// decoded byte with the bytes popped, in order.
module tb_fifo_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       tx_en      = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data  = 8'h00;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       byte_done;

    int         n_checks     = 0;
    int         n_pass       = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int         cyc          = 0;
    int         t0           = 0;
    int         last_rd      = -100;
    int         last_end     = -1000;
    int         pending_done = -1;
    int         exp_start    = -1;
    int         pops         = 0;
    int         dones        = 0;
    int         frames       = 0;
    bit         in_frame     = 1'b0;
    bit         gap_chk      = 1'b0;
    logic       prev_tx      = 1'b1;
    logic [7:0] shreg        = 8'h00;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .byte_done  (byte_done)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    // One clock cycle: wait for the falling edge, then model the FIFO and
    // check the serial line against the frame rules.
    task automatic tick();
        logic rst_applied;
        int   k;
        int   b;
        rst_applied = rst;
        @(negedge clk);
        cyc++;
        if (rst_applied) begin
            chk("rst_tx",        32'(tx),         32'd1);
            chk("rst_busy",      32'(busy),       32'd0);
            chk("rst_rd_en",     32'(fifo_rd_en), 32'd0);
            chk("rst_byte_done", 32'(byte_done),  32'd0);
            in_frame     = 1'b0;
            exp_q.delete();
            pending_done = -1;
            prev_tx      = 1'b1;
        end else begin
            if (fifo_rd_en) begin
                chk("rd_en_single_cycle", 32'(cyc - last_rd > 1), 32'd1);
                chk("rd_en_nonempty", 32'(fifo_q.size() > 0), 32'd1);
                if (fifo_q.size() > 0) begin
                    fifo_data = fifo_q.pop_front();
                    exp_q.push_back(fifo_data);
                end
                last_rd = cyc;
                pops++;
            end
            chk("byte_done", 32'(byte_done), 32'(cyc == pending_done));
            if (byte_done) dones++;
            if (!in_frame) begin
                if (prev_tx && !tx) begin
                    in_frame = 1'b1;
                    t0       = cyc;
                    frames++;
                    chk("rd_to_start", 32'(cyc - last_rd), 32'd2);
                    if (exp_start >= 0) begin
                        chk("start_latency", 32'(cyc), 32'(exp_start));
                        exp_start = -1;
                    end
                    if (gap_chk && last_end >= 0) begin
                        chk("frame_gap", 32'(cyc - last_end - 1), 32'd2);
                    end
                end else begin
                    chk("line_idle_high", 32'(tx), 32'd1);
                end
            end
            if (in_frame) begin
                k = cyc - t0;
                b = k / CPB;
                chk("busy_in_frame",  32'(busy),       32'd1);
                chk("rd_en_in_frame", 32'(fifo_rd_en), 32'd0);
                if (b == 0) begin
                    chk("start_bit", 32'(tx), 32'd0);
                end else if (b <= 8) begin
                    if (k % CPB == 0) shreg[b-1] = tx;
                    else chk("data_bit_stable", 32'(tx), 32'(shreg[b-1]));
                end else begin
                    chk("stop_bit", 32'(tx), 32'd1);
                end
                if (k == FRAME - 1) begin
                    in_frame     = 1'b0;
                    last_end     = cyc;
                    pending_done = cyc + 1;
                    if (exp_q.size() > 0) chk("decoded_byte", 32'(shreg), 32'(exp_q.pop_front()));
                    else chk("frame_has_popped_byte", 32'(exp_q.size()), 32'd1);
                end
            end
            prev_tx = tx;
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    // Run until the transmitter has gone idle, bounded by maxc cycles.
    task automatic run_idle(input int maxc);
        int n;
        n = 0;
        repeat (3) tick();
        while ((busy || in_frame) && n < maxc) begin
            tick();
            n++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    // Wait until the current frame reaches in-frame cycle target.
    task automatic wait_frame_cycle(input int target);
        int n;
        n = 0;
        while (!(in_frame && (cyc - t0) >= target) && n < 200) begin
            tick();
            n++;
        end
        chk("frame_point_reached", 32'(in_frame && (cyc - t0) == target), 32'd1);
    endtask

    initial begin
        int p0;
        int d0;
        int f0;
        int nb;

        // Reset held two cycles with data waiting, then a single 0xA5 frame.
        push(8'hA5);
        tx_en = 1'b1;
        rst   = 1'b1;
        tick();
        tick();
        rst       = 1'b0;
        exp_start = cyc + 3;
        run_idle(200);
        chk("single_pops",   32'(pops),   32'd1);
        chk("single_dones",  32'(dones),  32'd1);
        chk("single_frames", 32'(frames), 32'd1);

        // Back-to-back: 0x01, 0x02, 0x03, then a random burst.
        gap_chk  = 1'b1;
        last_end = -1000;
        p0 = pops; d0 = dones; f0 = frames;
        push(8'h01); push(8'h02); push(8'h03);
        run_idle(500);
        chk("b2b_pops",   32'(pops - p0),   32'd3);
        chk("b2b_dones",  32'(dones - d0),  32'd3);
        chk("b2b_frames", 32'(frames - f0), 32'd3);
        last_end = -1000;
        nb = $urandom_range(2, 5);
        p0 = pops; d0 = dones;
        for (int i = 0; i < nb; i++) push(8'($urandom_range(0, 255)));
        run_idle(600);
        chk("rand_pops",  32'(pops - p0),  32'(nb));
        chk("rand_dones", 32'(dones - d0), 32'(nb));
        gap_chk = 1'b0;

        // Empty FIFO with tx_en high: nothing happens.
        p0 = pops;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("empty_rd_en", 32'(fifo_rd_en), 32'd0);
            chk("empty_busy",  32'(busy),       32'd0);
        end
        chk("empty_no_pop", 32'(pops - p0), 32'd0);

        // tx_en dropped during DATA: frame finishes, second byte waits.
        p0 = pops; d0 = dones;
        push(8'($urandom_range(0, 255)));
        push(8'($urandom_range(0, 255)));
        wait_frame_cycle(CPB + $urandom_range(0, 8 * CPB - 1));
        tx_en = 1'b0;
        run_idle(200);
        chk("gate_one_pop",  32'(pops - p0),  32'd1);
        chk("gate_one_done", 32'(dones - d0), 32'd1);
        repeat (20) tick();
        chk("gate_no_more_pop", 32'(pops - p0),      32'd1);
        chk("gate_fifo_kept",   32'(fifo_q.size()),  32'd1);
        chk("gate_idle",        32'(busy),           32'd0);
        tx_en     = 1'b1;
        exp_start = cyc + 3;
        run_idle(200);
        chk("gate_resume_pop",  32'(pops - p0),  32'd2);
        chk("gate_resume_done", 32'(dones - d0), 32'd2);

        // Reset during data bit 3: byte dropped, next byte sent cleanly.
        p0 = pops; d0 = dones;
        push(8'($urandom_range(0, 255)));
        push(8'($urandom_range(0, 255)));
        wait_frame_cycle(4 * CPB + $urandom_range(0, CPB - 1));
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        exp_start = cyc + 3;
        run_idle(200);
        chk("rstmid_pops",  32'(pops - p0),  32'd2);
        chk("rstmid_dones", 32'(dones - d0), 32'd1);
        chk("rstmid_fifo_drained", 32'(fifo_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
